bin_to_bcd_converter: RTL and testbench
=======================================

# bin_to_bcd_converter

Sequential binary-to-BCD converter feeding the six-digit hex seven-segment controller. It takes an unsigned binary count, produces six packed BCD digits on `bcd_out[23:0]` (digit 0 in bits [3:0]), and holds that value stable between conversions, so the display shows decimal instead of hex. The conversion is iterative double-dabble (shift-and-add-3), one bit per clock, with a start/ready/valid handshake to the upstream producer.

## Interface
Parameters:
- `BIN_W`, default 20: width of the binary input. 20 bits covers 0..1048575.
- `DIGITS`, default 6: number of BCD digits. The output width is 4*DIGITS.

Ports:
- `clk`, in, 1: clock.
- `reset_n`, in, 1: reset; synchronous, active-low.
- `start`, in, 1: request a conversion. Sampled only while `ready` is 1.
- `bin_in`, in, BIN_W: unsigned value. Captured on the accepting edge.
- `ready`, out, 1: converter is idle and can accept `start`.
- `valid`, out, 1: single-cycle pulse; new `bcd_out`/`overflow` are available.
- `bcd_out`, out, 4*DIGITS: packed BCD result, registered, held until the next completion.
- `overflow`, out, 1: the last accepted `bin_in` exceeded 10^DIGITS−1. Updated together with `bcd_out`.

## Operation
- FSM has two states.
  - IDLE: `ready`=1.
  - CONVERT: `ready`=0.
- IDLE, when `start`=1 at an edge:
  - load the shift register with `bin_in`;
  - clear the BCD scratch register (4*DIGITS bits);
  - load the bit counter with BIN_W;
  - latch `ovf_q` = (`bin_in` > 10^DIGITS−1);
  - go to CONVERT.
- CONVERT, each edge:
  - every scratch digit ≥5 gets +3, applied to all digits in parallel;
  - then shift {scratch, shift register} left by 1, so the shift register MSB enters scratch bit 0;
  - decrement the counter.
- On the edge that performs the final (BIN_W-th) iteration:
  - write the post-shift scratch to `bcd_out`, or all digits 4'h9 if `ovf_q`;
  - write `overflow` = `ovf_q`;
  - set `valid` to 1 for one cycle;
  - return to IDLE.
- `start` while in CONVERT is ignored; there is no queueing.
- `bin_in` changes after acceptance have no effect.
- Scratch arithmetic is mod-16 per digit. For in-range inputs no digit exceeds 9. For out-of-range inputs scratch bits are discarded, since the result is overridden by the saturated value.
- Reset (`reset_n`=0 at an edge) overrides everything, including a conversion in progress. The conversion is aborted and no `valid` pulse is produced.

## Timing
- Reset values:
  - state IDLE;
  - `ready`=1;
  - `valid`=0;
  - `bcd_out`=0;
  - `overflow`=0;
  - counter, shift and scratch registers all 0.
- Start accepted at edge E0. `ready` is low from E0 until E0+BIN_W. At E0+BIN_W, `valid`, `ready`, `bcd_out` and `overflow` all update.
- Latency: BIN_W edges from acceptance to result (20 at default).
- Back-to-back: `start` held high while `valid`=1 is accepted at E0+BIN_W+1. Throughput is one conversion per BIN_W+1 cycles.
- Simultaneous `start` and reset: reset wins; state stays IDLE.
- `bcd_out` never changes except on a completion edge or on reset, so the downstream display never sees an intermediate value.

## Structure
- Shared package `sev_seg_pkg` holds:
  - `localparam DIGIT_W = 4`;
  - the FSM state typedef `conv_state_t {IDLE, CONVERT}`;
  - the function `max_dec(DIGITS)` returning 10^DIGITS−1;
  - the BCD nine constant `4'h9`.
- One sub-module, `bcd_digit_adj`: combinational 4-bit in/out, output = in+3 if in≥5, else in. It is instantiated DIGITS times via generate.
- The top module holds the FSM, counter, shift/scratch registers and output registers.

## Test plan
- Reset, then `bin_in`=0 with `start` pulse → `valid` exactly 20 cycles after acceptance, `bcd_out`=24'h000000, `overflow`=0.
- `bin_in`=123456 → `bcd_out`=24'h123456. Separately, `bin_in`=999999 → 24'h999999, `overflow`=0. `ready` is low for exactly 20 cycles in each case.
- `bin_in`=1000000 and `bin_in`=1048575 → `bcd_out`=24'h999999, `overflow`=1. A following `bin_in`=42 → 24'h000042, `overflow`=0.
- `start` pulsed with `bin_in`=777 mid-conversion of 5 → ignored; result 24'h000005, only one `valid` pulse.
- `start` held high continuously with `bin_in` stepping 1, 2, 3 at each acceptance → results 1, 2, 3, with `valid` pulses exactly 21 cycles apart.
- `reset_n` low for one cycle, 10 cycles into a conversion of 654321 → no `valid`, `bcd_out`=0, `ready`=1 the next cycle. A new conversion of 654321 then completes correctly.

Source files
------------

// File: rtl/sev_seg_pkg.sv
// Shared definitions for the seven-segment display path: digit width,
// converter FSM states and decimal range helpers.
package sev_seg_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_NINE = 4'h9;

    typedef enum logic {
        IDLE,
        CONVERT
    } conv_state_t;

    // Largest value representable in `digits` decimal digits (10^digits - 1).
    function automatic logic [63:0] max_dec(input int digits);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < digits; i++) begin
            r = r * 64'd10;
        end
        return r - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import sev_seg_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Iterative shift-and-add-3 binary to BCD converter, one input bit per clock.
// Out-of-range inputs saturate the result to all nines and flag overflow.
module bin_to_bcd_converter
    import sev_seg_pkg::*;
#(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin_in,
    output logic                    ready,
    output logic                    valid,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                    overflow
);

    localparam int SCR_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [63:0] MAX_VAL = max_dec(DIGITS);

    conv_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [SCR_W-1:0]   adj;
    logic [SCR_W-1:0]   bcd_q;
    logic               ovf_q;
    logic               overflow_q;
    logic               valid_q;
    logic               in_ovf;
    logic               last_iter;
    logic               unused_msb;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit_i (scratch_q[g*DIGIT_W +: DIGIT_W]),
                .digit_o (adj[g*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    // Correct all digits, then shift {scratch, shift} left by one; the scratch
    // MSB falls off (it only matters for out-of-range inputs, which saturate).
    assign {unused_msb, scratch_d} = {adj, shift_q[BIN_W-1]};
    assign shift_d   = shift_q << 1;
    assign in_ovf    = 64'(bin_in) > MAX_VAL;
    assign last_iter = (state_q == CONVERT) && (cnt_q == CNT_W'(1));

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)     state_d = CONVERT;
            CONVERT: if (last_iter) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        ready    = (state_q == IDLE);
        valid    = valid_q;
        bcd_out  = bcd_q;
        overflow = overflow_q;
    end

    // Datapath and result registers; results only move on a completion edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            shift_q    <= '0;
            scratch_q  <= '0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_q   <= bin_in;
                        scratch_q <= '0;
                        cnt_q     <= CNT_W'(BIN_W);
                        ovf_q     <= in_ovf;
                    end
                end
                CONVERT: begin
                    scratch_q <= scratch_d;
                    shift_q   <= shift_d;
                    cnt_q     <= cnt_q - CNT_W'(1);
                    if (last_iter) begin
                        bcd_q      <= ovf_q ? {DIGITS{BCD_NINE}} : scratch_d;
                        overflow_q <= ovf_q;
                        valid_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Bench for bin_to_bcd_converter: a cycle-count model of the handshake plus
// decimal arithmetic for the result, checked every cycle, with directed cases.
module tb_bin_to_bcd_converter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [19:0] bin_in = '0;
    logic        ready, valid, overflow;
    logic [23:0] bcd_out;

    bin_to_bcd_converter dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .bin_in   (bin_in),
        .ready    (ready),
        .valid    (valid),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_valid = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected decimal result from plain arithmetic, saturated above 999999.
    function automatic logic [23:0] exp_bcd(input int unsigned v);
        logic [23:0] r;
        int unsigned x;
        if (v > 999999) return 24'h999999;
        x = v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Model: a conversion occupies 20 cycles after acceptance, then one valid.
    int          m_busy = 0;
    int unsigned m_val = 0;
    logic        m_valid = 1'b0;
    logic [23:0] m_bcd = '0;
    logic        m_ovf = 1'b0;
    logic        m_ready;
    assign m_ready = (m_busy == 0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset_n) begin
            m_busy  <= 0;
            m_valid <= 1'b0;
            m_bcd   <= '0;
            m_ovf   <= 1'b0;
        end else begin
            m_valid <= 1'b0;
            if (m_busy != 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_valid <= 1'b1;
                    m_bcd   <= exp_bcd(m_val);
                    m_ovf   <= (m_val > 999999);
                end
            end else if (start) begin
                m_busy <= 20;
                m_val  <= bin_in;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("ready", ready, m_ready);
                chk("valid", valid, m_valid);
                chk("bcd_out", bcd_out, m_bcd);
                chk("overflow", overflow, m_ovf);
                if (valid) n_valid++;
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!ready && t < 100) begin @(negedge clk); t++; end
        if (!ready) chk("wait_ready_timeout", 0, 1);
    endtask

    task automatic run_conv(input string nm, input logic [19:0] v,
                            input logic [23:0] eb, input logic eo);
        int lat, rl;
        wait_ready();
        start = 1'b1; bin_in = v;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        rl = ready ? 0 : 1;
        while (!valid && lat < 45) begin
            @(negedge clk);
            lat++;
            if (!ready) rl++;
        end
        chk({nm, "_valid_seen"}, valid, 1);
        chk({nm, "_latency"}, lat - 1, 20);
        chk({nm, "_ready_low"}, rl, 20);
        chk({nm, "_bcd"}, bcd_out, eb);
        chk({nm, "_ovf"}, overflow, eo);
    endtask

    initial begin
        int nv0, t;
        int tv[3];
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_ready", ready, 1);
        chk("rst_valid", valid, 0);
        chk("rst_bcd", bcd_out, 24'h0);
        chk("rst_ovf", overflow, 0);
        reset_n = 1'b1;
        @(negedge clk);

        run_conv("zero", 20'd0, 24'h000000, 1'b0);
        run_conv("v123456", 20'd123456, 24'h123456, 1'b0);
        run_conv("v999999", 20'd999999, 24'h999999, 1'b0);
        run_conv("v1000000", 20'd1000000, 24'h999999, 1'b1);
        run_conv("vmax", 20'd1048575, 24'h999999, 1'b1);
        run_conv("v42", 20'd42, 24'h000042, 1'b0);

        // start mid-conversion is ignored, bin_in changes have no effect
        wait_ready();
        nv0 = n_valid;
        start = 1'b1; bin_in = 20'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; bin_in = 20'd777;
        @(negedge clk);
        start = 1'b0; bin_in = 20'd0;
        t = 0;
        while (!valid && t < 40) begin @(negedge clk); t++; end
        chk("ign_valid_seen", valid, 1);
        chk("ign_bcd", bcd_out, 24'h000005);
        repeat (25) @(negedge clk);
        chk("ign_one_pulse", n_valid - nv0, 1);

        // back-to-back with start held high
        wait_ready();
        start = 1'b1; bin_in = 20'd1;
        for (int k = 0; k < 3; k++) begin
            t = 0;
            do begin @(negedge clk); t++; end while (!valid && t < 45);
            tv[k] = cyc;
            chk($sformatf("b2b_bcd%0d", k + 1), bcd_out, 24'(k + 1));
            if (k < 2) bin_in = 20'(k + 2);
            else       start = 1'b0;
        end
        chk("b2b_gap1", tv[1] - tv[0], 21);
        chk("b2b_gap2", tv[2] - tv[1], 21);

        // reset aborts a conversion in progress
        wait_ready();
        start = 1'b1; bin_in = 20'd654321;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        nv0 = n_valid;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("abort_ready", ready, 1);
        chk("abort_bcd", bcd_out, 24'h0);
        chk("abort_valid", valid, 0);
        repeat (30) @(negedge clk);
        chk("abort_no_valid", n_valid - nv0, 0);
        run_conv("v654321", 20'd654321, 24'h654321, 1'b0);

        // reset wins over a simultaneous start
        reset_n = 1'b0; start = 1'b1; bin_in = 20'd9;
        @(negedge clk);
        reset_n = 1'b1; start = 1'b0;
        chk("rst_start_ready0", ready, 1);
        @(negedge clk);
        chk("rst_start_ready1", ready, 1);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
